// File: rtl/data_ram_responder.sv
// Word-organised data RAM for the CPU MEM stage: byte-lane stores,
// asynchronous lane-extracted loads, a registered debug port and a write counter.
module data_ram_responder #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-3:0] ram_addr,
  input  logic [31:0]          ram_data_in,
  input  logic [3:0]           ram_sel,
  input  logic                 ram_rw,
  input  logic                 ram_extend_type,
  output logic [31:0]          ram_data_out,
  input  logic [ADDR_BITS-3:0] dbg_addr,
  output logic [31:0]          dbg_data,
  output logic [31:0]          write_count
);

  localparam int WA    = ADDR_BITS - 2;
  localparam int DEPTH = 1 << WA;

  logic [31:0] r_mem [DEPTH] = '{default: 32'h0};
  logic [31:0] r_dbg;
  logic [31:0] r_wcnt;

  logic        w_full;
  logic        w_lo_h;
  logic        w_hi_h;
  logic        w_b0;
  logic        w_b1;
  logic        w_b2;
  logic        w_b3;
  logic        w_ext;
  logic        w_we;
  logic        w_cnt;
  logic [31:0] w_word;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  assign w_full = (ram_sel == 4'b1111);
  assign w_lo_h = (ram_sel == 4'b0011);
  assign w_hi_h = (ram_sel == 4'b1100);
  assign w_b0   = (ram_sel == 4'b0001);
  assign w_b1   = (ram_sel == 4'b0010);
  assign w_b2   = (ram_sel == 4'b0100);
  assign w_b3   = (ram_sel == 4'b1000);
  assign w_ext  = ram_extend_type;
  assign w_we   = ram_rw;
  assign w_cnt  = ram_rw & (|ram_sel);
  assign w_word = r_mem[ram_addr];

  // Move low-justified store data onto the lanes it targets.
  always_comb begin
    w_wdata = ram_data_in;
    unique case (1'b1)
      w_hi_h:
        w_wdata = {ram_data_in[15:0], 16'h0};
      w_b1:
        w_wdata = {16'h0, ram_data_in[7:0], 8'h0};
      w_b2:
        w_wdata = {8'h0, ram_data_in[7:0], 16'h0};
      w_b3:
        w_wdata = {ram_data_in[7:0], 24'h0};
      default:
        w_wdata = ram_data_in;
    endcase
  end

  always_comb begin
    w_rdata = w_word;
    unique case (1'b1)
      w_full:
        w_rdata = w_word;
      w_lo_h:
        w_rdata = {{16{w_ext & w_word[15]}},
                   w_word[15:0]};
      w_hi_h:
        w_rdata = {{16{w_ext & w_word[31]}},
                   w_word[31:16]};
      w_b0:
        w_rdata = {{24{w_ext & w_word[7]}},
                   w_word[7:0]};
      w_b1:
        w_rdata = {{24{w_ext & w_word[15]}},
                   w_word[15:8]};
      w_b2:
        w_rdata = {{24{w_ext & w_word[23]}},
                   w_word[23:16]};
      w_b3:
        w_rdata = {{24{w_ext & w_word[31]}},
                   w_word[31:24]};
      default:
        w_rdata = w_word;
    endcase
  end

  assign ram_data_out = w_rdata;

  // The array has no reset; rst only gates its write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbg  <= 32'h0;
      r_wcnt <= 32'h0;
    end else begin
      r_dbg <= r_mem[dbg_addr];
      if (w_cnt) begin
        r_wcnt <= r_wcnt + 32'd1;
      end
      if (w_we) begin
        for (int k = 0; k < 4; k++) begin
          if (ram_sel[k]) begin
            r_mem[ram_addr][8*k +: 8] <= w_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  assign dbg_data    = r_dbg;
  assign write_count = r_wcnt;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: fixed vector table, hand-written
// collision/reset sequences, then random traffic against a word-array model.
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  ram_addr = '0;
  logic [31:0] ram_data_in = '0;
  logic [3:0]  ram_sel = '0;
  logic        ram_rw = 1'b0;
  logic        ram_extend_type = 1'b0;
  logic [31:0] ram_data_out;
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [31:0] write_count;

  data_ram_responder #(.ADDR_BITS(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .ram_addr        (ram_addr),
    .ram_data_in     (ram_data_in),
    .ram_sel         (ram_sel),
    .ram_rw          (ram_rw),
    .ram_extend_type (ram_extend_type),
    .ram_data_out    (ram_data_out),
    .dbg_addr        (dbg_addr),
    .dbg_data        (dbg_data),
    .write_count     (write_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem_m [1024];
  logic [31:0] wc_m;
  logic [31:0] dbg_m;

  typedef struct {
    logic        rw;
    logic [9:0]  addr;
    logic [3:0]  sel;
    logic [31:0] din;
    logic        ext;
    logic [31:0] exp_out;
    logic [31:0] exp_wc;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(logic [31:0] w, logic [3:0] s,
                                         logic e);
    logic [31:0] v;
    int bits;
    case (s)
      4'hF: return w;
      4'h3: begin v = w & 32'hFFFF; bits = 16; end
      4'hC: begin v = w >> 16; bits = 16; end
      4'h1: begin v = w & 32'hFF; bits = 8; end
      4'h2: begin v = (w >> 8) & 32'hFF; bits = 8; end
      4'h4: begin v = (w >> 16) & 32'hFF; bits = 8; end
      4'h8: begin v = w >> 24; bits = 8; end
      default: return w;
    endcase
    if (e && v[bits-1]) v = v | (32'hFFFFFFFF << bits);
    return v;
  endfunction

  task automatic m_write(logic [9:0] a, logic [31:0] d, logic [3:0] s);
    int sh;
    for (int k = 0; k < 4; k++) begin
      if (s[k]) begin
        if (s == 4'hC) sh = 8 * (k - 2);
        else if ($countones(s) == 1) sh = 0;
        else sh = 8 * k;
        mem_m[a][8*k +: 8] = 8'(d >> sh);
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (rst) begin
      wc_m  = 0;
      dbg_m = 0;
    end else begin
      dbg_m = mem_m[dbg_addr];
      if (ram_rw) begin
        m_write(ram_addr, ram_data_in, ram_sel);
        if (ram_sel != 0) wc_m = wc_m + 1;
      end
    end
    #1;
  endtask

  task automatic drive(logic rw, logic [9:0] a, logic [3:0] s,
                       logic [31:0] d, logic e, logic [9:0] dba);
    ram_rw          = rw;
    ram_addr        = a;
    ram_sel         = s;
    ram_data_in     = d;
    ram_extend_type = e;
    dbg_addr        = dba;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
    wc_m  = 0;
    dbg_m = 0;

    tbl[0]  = '{1'b1, 10'd5, 4'hF, 32'h12345678, 1'b0, 32'h00000000, 32'd1};
    tbl[1]  = '{1'b0, 10'd5, 4'hF, 32'h0,        1'b0, 32'h12345678, 32'd1};
    tbl[2]  = '{1'b1, 10'd5, 4'h4, 32'h000000AB, 1'b0, 32'h00000034, 32'd2};
    tbl[3]  = '{1'b0, 10'd5, 4'hF, 32'h0,        1'b0, 32'h12AB5678, 32'd2};
    tbl[4]  = '{1'b0, 10'd5, 4'h4, 32'h0,        1'b1, 32'hFFFFFFAB, 32'd2};
    tbl[5]  = '{1'b0, 10'd5, 4'h4, 32'h0,        1'b0, 32'h000000AB, 32'd2};
    tbl[6]  = '{1'b1, 10'd7, 4'hC, 32'h00008001, 1'b0, 32'h00000000, 32'd3};
    tbl[7]  = '{1'b0, 10'd7, 4'hF, 32'h0,        1'b0, 32'h80010000, 32'd3};
    tbl[8]  = '{1'b0, 10'd7, 4'hC, 32'h0,        1'b1, 32'hFFFF8001, 32'd3};
    tbl[9]  = '{1'b0, 10'd7, 4'h3, 32'h0,        1'b1, 32'h00000000, 32'd3};
    tbl[10] = '{1'b1, 10'd5, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h12AB5678, 32'd3};
    tbl[11] = '{1'b0, 10'd5, 4'hF, 32'h0,        1'b0, 32'h12AB5678, 32'd3};
    tbl[12] = '{1'b0, 10'd5, 4'h5, 32'h0,        1'b1, 32'h12AB5678, 32'd3};
    tbl[13] = '{1'b0, 10'd5, 4'h2, 32'h0,        1'b1, 32'h00000056, 32'd3};
    tbl[14] = '{1'b0, 10'd5, 4'h3, 32'h0,        1'b1, 32'h00005678, 32'd3};
    tbl[15] = '{1'b1, 10'd5, 4'hA, 32'hAABBCCDD, 1'b0, 32'h12AB5678, 32'd4};
    tbl[16] = '{1'b0, 10'd5, 4'hF, 32'h0,        1'b0, 32'hAAABCC78, 32'd4};

    // Power-up reset, array starts at zero and ignores writes under reset
    #1 rst = 1'b1;
    #1;
    chk("reset wc", write_count, 32'h0);
    chk("reset dbg", dbg_data, 32'h0);
    drive(1'b1, 10'd5, 4'hF, 32'hFFFFFFFF, 1'b0, 10'd5);
    #1 chk("zero init", ram_data_out, 32'h0);
    edge_step();
    edge_step();
    chk("wc under rst", write_count, 32'h0);
    chk("no write under rst", ram_data_out, 32'h0);
    rst = 1'b0;
    drive(1'b0, 10'd0, 4'hF, 32'h0, 1'b0, 10'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].rw, tbl[i].addr, tbl[i].sel, tbl[i].din, tbl[i].ext, 10'd0);
      #1 chk($sformatf("tbl%0d out", i), ram_data_out, tbl[i].exp_out);
      edge_step();
      chk($sformatf("tbl%0d wc", i), write_count, tbl[i].exp_wc);
    end

    // Write/read collision on word 9
    drive(1'b1, 10'd9, 4'hF, 32'h1, 1'b0, 10'd0);
    edge_step();
    drive(1'b1, 10'd9, 4'hF, 32'h2, 1'b0, 10'd9);
    #1 chk("coll pre", ram_data_out, 32'h1);
    edge_step();
    chk("coll post", ram_data_out, 32'h2);
    chk("coll dbg1", dbg_data, 32'h1);
    drive(1'b0, 10'd9, 4'hF, 32'h0, 1'b0, 10'd9);
    edge_step();
    chk("coll dbg2", dbg_data, 32'h2);
    chk("coll wc", write_count, 32'd6);

    // Asynchronous reset between edges
    rst = 1'b1;
    #1;
    wc_m  = 0;
    dbg_m = 0;
    chk("async rst wc", write_count, 32'h0);
    chk("async rst dbg", dbg_data, 32'h0);
    drive(1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0, 10'd5);
    edge_step();
    chk("rst hold wc", write_count, 32'h0);
    chk("rst hold dbg", dbg_data, 32'h0);
    drive(1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 10'd5);
    #1 chk("rst keeps array", ram_data_out, 32'hAAABCC78);
    rst = 1'b0;
    drive(1'b1, 10'd11, 4'hF, 32'h55, 1'b0, 10'd5);
    edge_step();
    chk("post rst wc", write_count, 32'd1);
    chk("post rst dbg", dbg_data, 32'hAAABCC78);
    drive(1'b0, 10'd11, 4'hF, 32'h0, 1'b0, 10'd11);
    #1 chk("post rst write", ram_data_out, 32'h55);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] s;
      case ($urandom_range(0, 8))
        0: s = 4'hF;
        1: s = 4'h3;
        2: s = 4'hC;
        3: s = 4'h1;
        4: s = 4'h2;
        5: s = 4'h4;
        6: s = 4'h8;
        7: s = 4'h0;
        default: s = 4'($urandom);
      endcase
      drive(1'($urandom), 10'($urandom_range(0, 15)), s, $urandom,
            1'($urandom), 10'($urandom_range(0, 15)));
      #1 chk("rnd out", ram_data_out, m_read(mem_m[ram_addr], s, ram_extend_type));
      if (i % 97 == 50) begin
        rst = 1'b1;
        #1;
        wc_m  = 0;
        dbg_m = 0;
        chk("rnd rst wc", write_count, wc_m);
        rst = 1'b0;
      end
      edge_step();
      chk("rnd wc", write_count, wc_m);
      chk("rnd dbg", dbg_data, dbg_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 12, byte-address width; word array depth = 2^(ADDR_BITS-2) (1024 words at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ram_addr  input  ADDR_BITS-2  word address from CPU MEM stage.
REQ-005 ram_data_in  input  32  store data, low-justified (byte in [7:0], halfword in [15:0]).
REQ-006 ram_sel  input  4  byte-lane enables; bit k = lane k = bits [8k+7:8k].
REQ-007 ram_rw  input  1  1 = write this cycle, 0 = read.
REQ-008 ram_extend_type  input  1  1 = sign-extend partial reads, 0 = zero-extend.
REQ-009 ram_data_out  output  32  combinational load data, lane-extracted and extended.
REQ-010 dbg_addr  input  ADDR_BITS-2  debug/display word address.
REQ-011 dbg_data  output  32  registered raw word at dbg_addr.
REQ-012 write_count  output  32  number of committed write cycles.

Function
REQ-013 Storage SHALL be a 2^(ADDR_BITS-2) x 32 array, all words zero at time zero.
REQ-014 Write: when ram_rw=1 at a rising clk edge, each lane k with ram_sel[k]=1 SHALL be written; unselected lanes SHALL keep their value.
REQ-015 Write lane mapping: sel 1111 -> full word; sel 0011 -> data_in[15:0] into lanes 1:0; sel 1100 -> data_in[15:0] into lanes 3:2; single-lane sel (0001/0010/0100/1000) -> data_in[7:0] into that lane.
REQ-016 Any other sel pattern with ram_rw=1 SHALL write ram_data_in lane-for-lane (lane k <- data_in[8k+7:8k]) for each selected lane; sel 0000 writes nothing.
REQ-017 Read SHALL be asynchronous: ram_data_out depends combinationally on ram_addr, ram_sel, ram_extend_type and array contents, zero cycle latency.
REQ-018 Read extraction: sel 1111 -> full word; 0011 -> lanes 1:0; 1100 -> lanes 3:2; single lane -> that byte; result right-justified to bit 0.
REQ-019 Partial read upper bits SHALL be copies of the extracted MSB when ram_extend_type=1, zero when 0; ram_extend_type ignored for sel 1111.
REQ-020 Other sel patterns (incl. 0000) SHALL return the raw stored word.
REQ-021 ram_data_out SHALL be driven also while ram_rw=1; same-cycle read of a word being written SHALL return the pre-edge (old) contents.
REQ-022 dbg_data SHALL register array[dbg_addr] each edge: 1-cycle latency; when a write to dbg_addr commits on the same edge, dbg_data SHALL show the old word, new word on the following edge.
REQ-023 write_count SHALL increment by 1 on each edge with ram_rw=1 and ram_sel != 0000; wraps 0xFFFFFFFF -> 0.
REQ-024 Addresses out of range cannot occur (address width equals depth); no wrap logic needed.

Reset
REQ-025 On rst=1, dbg_data and write_count SHALL clear to 0 immediately, without waiting for clk.
REQ-026 Array contents SHALL NOT be affected by rst; writes SHALL be blocked while rst=1.
REQ-027 After rst deassertion, the first rising edge SHALL perform normal writes and dbg capture.

Verification
REQ-028 Word: write addr 5, sel 1111, data 0x12345678 -> read addr 5 sel 1111 = 0x12345678; write_count = 1.
REQ-029 Byte store/load: after REQ-028, write addr 5 sel 0100 data 0x000000AB -> word = 0x12AB5678; read sel 0100 ext=1 -> 0xFFFFFFAB, ext=0 -> 0x000000AB.
REQ-030 Halfword: write addr 7 sel 1100 data 0x00008001 -> word = 0x80010000; read sel 1100 ext=1 -> 0xFFFF8001; sel 0011 ext=1 -> 0x00000000.
REQ-031 Write-read collision: addr 9 holds 0x1, drive rw=1 sel 1111 data 0x2 with dbg_addr=9 -> ram_data_out = 0x1 before edge, 0x2 after; dbg_data = 0x1 after edge 1, 0x2 after edge 2.
REQ-032 Reset mid-run: write_count = 3, assert rst between edges -> write_count = 0 and dbg_data = 0 before next edge; rw=1 edge during rst leaves array unchanged; previously written words still read back.
REQ-033 sel 0000 with rw=1 -> no array change, write_count unchanged.
